// File: rtl/bus_xfer_seq.sv
// bus_xfer_seq: transfer sequencer for the shared 16-bit word bus.
// Requests (register-to-register or immediate-to-register) are queued in a
// small FIFO and executed one at a time as DRIVE -> WRITE -> DONE. At most
// one bus driver is active in any cycle.
// Optional build macro BUS_XFER_COUNT_EN adds o_xfer_count, a wrapping count
// of completed transfers.
module bus_xfer_seq #(
  parameter int NREG  = 8,
  parameter int DEPTH = 4
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_imm,
  input  logic [$clog2(NREG)-1:0]   i_req_src,
  input  logic [$clog2(NREG)-1:0]   i_req_dst,
  input  logic [0:15]               i_req_data,
  output logic [NREG-1:0]           o_sel,
  output logic [NREG-1:0]           o_wen,
  output logic                      o_imm_drive,
  output logic [0:15]               o_imm_data,
`ifdef BUS_XFER_COUNT_EN
  output logic [0:15]               o_xfer_count,
`endif
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int IW = $clog2(NREG);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic          imm;
    logic [IW-1:0] src;
    logic [IW-1:0] dst;
    logic [0:15]   data;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  req_t          fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  req_t          work_q, work_d;
  req_t          req_in;

  logic            full, empty, push, pop;
  logic            src_ok, dst_ok;
  logic [NREG-1:0] sel_d, wen_d;
  logic            drv_d, done_d;
  logic [0:15]     imm_d;

  logic [NREG-1:0] sel_q, wen_q;
  logic            drv_q, done_q;
  logic [0:15]     imm_q;

  assign req_in = '{imm: i_req_imm, src: i_req_src, dst: i_req_dst, data: i_req_data};

  // Ready is purely !full, so a pop in the same cycle never opens a slot early.
  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign o_req_ready = ~full;
  assign push        = i_req_valid & ~full;
  assign pop         = (state_q == S_IDLE) & ~empty;

  // FIFO storage: data only, no reset needed.
  always_ff @(posedge i_clock) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= req_in;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH (power of 2).
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Next-state logic; the working request is latched when leaving IDLE.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          work_d  = fifo_q[rd_ptr_q];
          state_d = S_DRIVE;
        end
      end
      S_DRIVE: state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state so all bus controls are registered.
  // A request naming any out-of-range register performs no select and no write.
  always_comb begin
    sel_d  = '0;
    wen_d  = '0;
    drv_d  = 1'b0;
    imm_d  = '0;
    done_d = 1'b0;
    src_ok = (int'(work_d.src) < NREG);
    dst_ok = (int'(work_d.dst) < NREG);
    case (state_d)
      S_DRIVE, S_WRITE: begin
        if (work_d.imm) begin
          if (dst_ok) begin
            drv_d = 1'b1;
            imm_d = work_d.data;
          end
        end else if (src_ok && dst_ok) begin
          sel_d = NREG'(1) << work_d.src;
        end
        if ((state_d == S_WRITE) && dst_ok && (work_d.imm || src_ok)) begin
          wen_d = NREG'(1) << work_d.dst;
        end
      end
      S_DONE:  done_d = 1'b1;
      default: ;
    endcase
  end

  // State, working request and registered bus controls.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      wen_q   <= '0;
      drv_q   <= 1'b0;
      imm_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wen_q   <= wen_d;
      drv_q   <= drv_d;
      imm_q   <= imm_d;
      done_q  <= done_d;
    end
  end

  // Working request register: data only.
  always_ff @(posedge i_clock) begin
    work_q <= work_d;
  end

  assign o_sel       = sel_q;
  assign o_wen       = wen_q;
  assign o_imm_drive = drv_q;
  assign o_imm_data  = imm_q;
  assign o_done      = done_q;
  assign o_busy      = (state_q != S_IDLE) | (count_q != '0);

`ifdef BUS_XFER_COUNT_EN
  logic [0:15] xcnt_q;

  // Completed-transfer counter, wraps from 16'hFFFF to 0.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      xcnt_q <= '0;
    end else if (done_q) begin
      xcnt_q <= xcnt_q + 16'd1;
    end
  end

  assign o_xfer_count = xcnt_q;
`endif

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Directed testbench for bus_xfer_seq: an NREG=8 instance and an NREG=6
// instance share the same stimulus.
module tb_bus_xfer_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, imm;
  logic [2:0]  src, dst;
  logic [0:15] data;

  logic        ready8, drv8, busy8, done8;
  logic [7:0]  sel8, wen8;
  logic [0:15] idata8;
  logic        ready6, drv6, busy6, done6;
  logic [5:0]  sel6, wen6;
  logic [0:15] idata6;
`ifdef BUS_XFER_COUNT_EN
  logic [0:15] cnt8, cnt6;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bus_xfer_seq #(.NREG(8), .DEPTH(4)) u_dut8 (
    .i_clock(clk), .i_reset(rst), .i_req_valid(valid), .o_req_ready(ready8),
    .i_req_imm(imm), .i_req_src(src), .i_req_dst(dst), .i_req_data(data),
    .o_sel(sel8), .o_wen(wen8), .o_imm_drive(drv8), .o_imm_data(idata8),
`ifdef BUS_XFER_COUNT_EN
    .o_xfer_count(cnt8),
`endif
    .o_busy(busy8), .o_done(done8)
  );

  bus_xfer_seq #(.NREG(6), .DEPTH(4)) u_dut6 (
    .i_clock(clk), .i_reset(rst), .i_req_valid(valid), .o_req_ready(ready6),
    .i_req_imm(imm), .i_req_src(src), .i_req_dst(dst), .i_req_data(data),
    .o_sel(sel6), .o_wen(wen6), .o_imm_drive(drv6), .o_imm_data(idata6),
`ifdef BUS_XFER_COUNT_EN
    .o_xfer_count(cnt6),
`endif
    .o_busy(busy6), .o_done(done6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0; imm = 1'b0; src = '0; dst = '0; data = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (sel8 !== 8'h00 || wen8 !== 8'h00 || drv8 !== 1'b0 || idata8 !== 16'h0 || done8 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: sel=%h wen=%h drv=%b data=%h done=%b, required all 0", sel8, wen8, drv8, idata8, done8);
    end
    n_cmp++;
    if (busy8 !== 1'b0 || ready8 !== 1'b1) begin
      n_err++;
      $display("FAIL reset_status: busy=%b ready=%b, required busy=0 ready=1", busy8, ready8);
    end
`ifdef BUS_XFER_COUNT_EN
    n_cmp++;
    if (cnt8 !== 16'h0) begin
      n_err++;
      $display("FAIL reset_count: %h, required 0000", cnt8);
    end
`endif
  endtask

  // Push src=2 dst=5 at edge 1; cycles counted as the interval after edge k-1.
  task automatic test_reg_xfer();
    valid = 1'b1; imm = 1'b0; src = 3'd2; dst = 3'd5;
    tick();
    valid = 1'b0;
    n_cmp++;
    if (sel8 !== 8'h00 || busy8 !== 1'b1) begin
      n_err++;
      $display("FAIL reg_c2: sel=%b busy=%b, required sel=0 busy=1", sel8, busy8);
    end
    tick();
    n_cmp++;
    if (sel8 !== 8'b00000100 || wen8 !== 8'h00) begin
      n_err++;
      $display("FAIL reg_c3_drive: sel=%b wen=%b, required sel=00000100 wen=0", sel8, wen8);
    end
    tick();
    n_cmp++;
    if (sel8 !== 8'b00000100 || wen8 !== 8'b00100000) begin
      n_err++;
      $display("FAIL reg_c4_write: sel=%b wen=%b, required sel=00000100 wen=00100000", sel8, wen8);
    end
    tick();
    n_cmp++;
    if (sel8 !== 8'h00 || wen8 !== 8'h00 || done8 !== 1'b1) begin
      n_err++;
      $display("FAIL reg_c5_done: sel=%b wen=%b done=%b, required 0 0 1", sel8, wen8, done8);
    end
    tick();
    n_cmp++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      n_err++;
      $display("FAIL reg_c6_idle: done=%b busy=%b, required 0 0", done8, busy8);
    end
  endtask

  task automatic test_imm();
    valid = 1'b1; imm = 1'b1; src = 3'd6; dst = 3'd0; data = 16'hBEEF;
    tick();
    valid = 1'b0; imm = 1'b0; data = 16'h0;
    tick();
    n_cmp++;
    if (drv8 !== 1'b1 || idata8 !== 16'hBEEF || sel8 !== 8'h00 || wen8 !== 8'h00) begin
      n_err++;
      $display("FAIL imm_drive: drv=%b data=%h sel=%b wen=%b, required 1 BEEF 0 0", drv8, idata8, sel8, wen8);
    end
    tick();
    n_cmp++;
    if (drv8 !== 1'b1 || idata8 !== 16'hBEEF || sel8 !== 8'h00 || wen8 !== 8'b00000001) begin
      n_err++;
      $display("FAIL imm_write: drv=%b data=%h sel=%b wen=%b, required 1 BEEF 0 00000001", drv8, idata8, sel8, wen8);
    end
    tick();
    n_cmp++;
    if (drv8 !== 1'b0 || sel8 !== 8'h00 || wen8 !== 8'h00 || done8 !== 1'b1) begin
      n_err++;
      $display("FAIL imm_done: drv=%b sel=%b wen=%b done=%b, required 0 0 0 1", drv8, sel8, wen8, done8);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0] s_tab [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
    logic [2:0] d_tab [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
    int  k = 0, w = 0, nd = 0, last_done = -1, k_at_low = -1;
    bit  excl_bad = 1'b0, order_bad = 1'b0, gap_bad = 1'b0;
    bit  acc;
    logic [7:0] exp_wen;
    for (int c = 0; c < 80; c++) begin
      if (($countones(sel8) + int'(drv8)) > 1) excl_bad = 1'b1;
      if (sel8 !== 8'h00 && drv8 === 1'b1) excl_bad = 1'b1;
      if (wen8 !== 8'h00) begin
        exp_wen = (w < 6) ? (8'd1 << d_tab[w]) : 8'h00;
        if (wen8 !== exp_wen) order_bad = 1'b1;
        w++;
      end
      if (done8 === 1'b1) begin
        if (last_done >= 0 && (c - last_done) != 4) gap_bad = 1'b1;
        last_done = c;
        nd++;
      end
      if (ready8 === 1'b0 && k_at_low < 0) k_at_low = k;
      if (nd == 6) break;
      if (k < 6) begin
        valid = 1'b1; imm = 1'b0; src = s_tab[k]; dst = d_tab[k];
      end else begin
        valid = 1'b0;
      end
      acc = (k < 6) && (ready8 === 1'b1);
      tick();
      if (acc) k++;
    end
    valid = 1'b0;
    n_cmp++;
    if (nd != 6 || w != 6) begin
      n_err++;
      $display("FAIL b2b_complete: dones=%0d writes=%0d, required 6 6", nd, w);
    end
    n_cmp++;
    if (order_bad) begin
      n_err++;
      $display("FAIL b2b_order: out-of-order or wrong o_wen=1, required 0");
    end
    n_cmp++;
    if (gap_bad) begin
      n_err++;
      $display("FAIL b2b_spacing: done gap not 4 cycles=1, required 0");
    end
    n_cmp++;
    if (excl_bad) begin
      n_err++;
      $display("FAIL b2b_exclusive: multiple bus drivers seen=1, required 0");
    end
    // One request is already popped into the FSM, so the 4-entry FIFO fills
    // only after the 5th acceptance.
    n_cmp++;
    if (k_at_low != 5) begin
      n_err++;
      $display("FAIL b2b_ready_drop: accepted before ready low=%0d, required 5", k_at_low);
    end
    tick();
    n_cmp++;
    if (busy8 !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: busy=%b, required 0", busy8);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    bit late_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1; imm = 1'b0; src = 3'(i); dst = 3'(i + 1);
      tick();
    end
    valid = 1'b0;
    // First WRITE seen from here belongs to the second transfer, 3 queued.
    for (int c = 0; c < 20; c++) begin
      if (wen8 !== 8'h00) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    n_cmp++;
    if (!found || busy8 !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_write_found: found=%b busy=%b, required 1 1", found, busy8);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (sel8 !== 8'h00 || wen8 !== 8'h00 || drv8 !== 1'b0 || done8 !== 1'b0 || busy8 !== 1'b0 || ready8 !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_outputs: sel=%h wen=%h drv=%b done=%b busy=%b ready=%b, required 0 0 0 0 0 1",
               sel8, wen8, drv8, done8, busy8, ready8);
    end
    for (int c = 0; c < 10; c++) begin
      tick();
      if (done8 !== 1'b0 || wen8 !== 8'h00 || sel8 !== 8'h00 || busy8 !== 1'b0) late_bad = 1'b1;
    end
    n_cmp++;
    if (late_bad) begin
      n_err++;
      $display("FAIL rstmid_discard: activity after reset=1, required 0");
    end
  endtask

  task automatic test_range();
    bit act6 = 1'b0;
    bit done_seen = 1'b0;
    valid = 1'b1; imm = 1'b0; src = 3'd7; dst = 3'd1;
    tick();
    valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (sel6 !== 6'h00 || wen6 !== 6'h00 || drv6 !== 1'b0) act6 = 1'b1;
      if (done6 === 1'b1) done_seen = 1'b1;
      tick();
    end
    n_cmp++;
    if (act6 || !done_seen) begin
      n_err++;
      $display("FAIL range_src7: bus activity=%b done seen=%b, required 0 1", act6, done_seen);
    end
    valid = 1'b1; src = 3'd3; dst = 3'd3;
    tick();
    valid = 1'b0;
    tick();
    n_cmp++;
    if (sel6 !== 6'b001000 || wen6 !== 6'h00) begin
      n_err++;
      $display("FAIL same_drive: sel=%b wen=%b, required 001000 000000", sel6, wen6);
    end
    tick();
    n_cmp++;
    if (sel6 !== 6'b001000 || wen6 !== 6'b001000 || sel8 !== 8'b00001000 || wen8 !== 8'b00001000) begin
      n_err++;
      $display("FAIL same_write: sel6=%b wen6=%b sel8=%b wen8=%b, required bit 3 in all", sel6, wen6, sel8, wen8);
    end
    tick();
    n_cmp++;
    if (done6 !== 1'b1) begin
      n_err++;
      $display("FAIL same_done: done=%b, required 1", done6);
    end
    tick();
  endtask

`ifdef BUS_XFER_COUNT_EN
  task automatic test_count();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1; imm = 1'b0; src = 3'(i); dst = 3'(i + 4);
      tick();
    end
    valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (busy8 === 1'b0) break;
      tick();
    end
    tick();
    n_cmp++;
    if (cnt8 !== 16'd3) begin
      n_err++;
      $display("FAIL count_three: %h, required 0003", cnt8);
    end
    force u_dut8.xcnt_q = 16'hFFFF;
    tick();
    release u_dut8.xcnt_q;
    valid = 1'b1; src = 3'd1; dst = 3'd2;
    tick();
    valid = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    n_cmp++;
    if (cnt8 !== 16'h0000) begin
      n_err++;
      $display("FAIL count_wrap: %h, required 0000", cnt8);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reg_xfer();
    test_imm();
    test_back_to_back();
    test_reset_mid();
    test_range();
`ifdef BUS_XFER_COUNT_EN
    test_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
